// File: rtl/nes_pad_reader.sv
// nes_pad_reader: serial game-pad reader driving a shared LATCH/PULSE pair to
// NUM_PADS pads, each returning NUM_BITS active-low bits on its own DATA line.
// The finished scan of every pad is published together in the DONE cycle.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for START or AUTO; all pad lines low
// S_LATCH_HI | LATCH high for two half periods
// S_LATCH_LO | LATCH low for one half period; bit 0 sampled in last cycle
// S_PULSE_HI | PULSE high for one half period
// S_PULSE_LO | PULSE low for one half period; bit r_bit sampled in last cycle
// S_DONE     | one cycle: BUTTONS/PRESSED updated, VALID high
module nes_pad_reader #(
    parameter int NUM_PADS    = 2,
    parameter int NUM_BITS    = 8,
    parameter int HALF_PERIOD = 162
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_auto,
    input  logic [NUM_PADS-1:0]          i_data,
    output logic                         o_latch,
    output logic                         o_pulse,
    output logic [NUM_PADS*NUM_BITS-1:0] o_buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] o_pressed,
    output logic                         o_valid,
    output logic                         o_busy
);

    localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int TW = NUM_PADS * NUM_BITS;
    localparam logic [PW-1:0] PRESC_LAST = PW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LATCH_HI = 3'd1,
        S_LATCH_LO = 3'd2,
        S_PULSE_HI = 3'd3,
        S_PULSE_LO = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PW-1:0]   r_presc;
    logic            r_latch_second;
    logic [BW-1:0]   r_bit;
    logic [TW-1:0]   r_capture;
    logic [TW-1:0]   r_buttons;
    logic [TW-1:0]   r_pressed;
    logic [TW-1:0]   w_capture_next;
    logic            w_phase_end;
    logic            w_request;
    logic            w_start_scan;
    logic            w_sample;
    logic            w_finish;

    assign w_phase_end = (r_presc == PRESC_LAST);
    assign w_request   = i_start | i_auto;

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the sample/finish/start events it implies.
    always_comb begin
        w_next_state = r_state;
        w_start_scan = 1'b0;
        w_sample     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_request) begin
                    w_next_state = S_LATCH_HI;
                    w_start_scan = 1'b1;
                end
            end
            S_LATCH_HI: begin
                if (w_phase_end && r_latch_second) begin
                    w_next_state = S_LATCH_LO;
                end
            end
            S_LATCH_LO: begin
                if (w_phase_end) begin
                    w_sample = 1'b1;
                    if (NUM_BITS == 1) begin
                        w_next_state = S_DONE;
                        w_finish     = 1'b1;
                    end else begin
                        w_next_state = S_PULSE_HI;
                    end
                end
            end
            S_PULSE_HI: begin
                if (w_phase_end) begin
                    w_next_state = S_PULSE_LO;
                end
            end
            S_PULSE_LO: begin
                if (w_phase_end) begin
                    w_sample = 1'b1;
                    if (r_bit == BIT_LAST) begin
                        w_next_state = S_DONE;
                        w_finish     = 1'b1;
                    end else begin
                        w_next_state = S_PULSE_HI;
                    end
                end
            end
            S_DONE: begin
                if (w_request) begin
                    w_next_state = S_LATCH_HI;
                    w_start_scan = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Capture register with the current bit of every pad merged in; the
    // bit loop keeps all indices constant so no wide variable select is built.
    always_comb begin
        w_capture_next = r_capture;
        for (int p = 0; p < NUM_PADS; p++) begin
            for (int k = 0; k < NUM_BITS; k++) begin
                if (BW'(k) == r_bit) begin
                    w_capture_next[p*NUM_BITS + k] = ~i_data[p];
                end
            end
        end
    end

    // Prescaler, latch phase counter, bit index, capture and published results.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_presc        <= '0;
            r_latch_second <= 1'b0;
            r_bit          <= '0;
            r_capture      <= '0;
            r_buttons      <= '0;
            r_pressed      <= '0;
        end else begin
            if (w_start_scan) begin
                r_presc        <= '0;
                r_latch_second <= 1'b0;
                r_bit          <= '0;
                r_capture      <= '0;
            end else if (o_busy) begin
                r_presc <= w_phase_end ? '0 : r_presc + 1'b1;
                if (r_state == S_LATCH_HI && w_phase_end) begin
                    r_latch_second <= ~r_latch_second;
                end
            end
            if (w_sample) begin
                r_capture <= w_capture_next;
                r_bit     <= w_finish ? '0 : r_bit + 1'b1;
            end
            // Results are loaded on the edge into DONE so they are visible
            // together with VALID; PRESSED lasts only that one cycle.
            if (w_finish) begin
                r_buttons <= w_capture_next;
                r_pressed <= w_capture_next & ~r_buttons;
            end else begin
                r_pressed <= '0;
            end
        end
    end

    assign o_latch   = (r_state == S_LATCH_HI);
    assign o_pulse   = (r_state == S_PULSE_HI);
    assign o_valid   = (r_state == S_DONE);
    assign o_busy    = (r_state == S_LATCH_HI) || (r_state == S_LATCH_LO) ||
                       (r_state == S_PULSE_HI) || (r_state == S_PULSE_LO);
    assign o_buttons = r_buttons;
    assign o_pressed = r_pressed;

endmodule
